// File: rtl/cam_pkg.sv
// Shared definitions for the CAM tag array: operation codes applied to the tag register file.
package cam_pkg;

  localparam int TAG_OP_W = 3;

  typedef enum logic [TAG_OP_W-1:0] {
    TAG_NOP          = 3'd0,
    TAG_SET_ALL      = 3'd1,
    TAG_CLEAR_ALL    = 3'd2,
    TAG_LOAD         = 3'd3,
    TAG_AND          = 3'd4,
    TAG_OR           = 3'd5,
    TAG_SELECT_FIRST = 3'd6,
    TAG_STEP         = 3'd7
  } tag_op_t;

endpackage

// File: rtl/cam_first_resolver.sv
// Find-first-set over the tag vector: log-depth prefix-OR tree yielding found flag, index and one-hot mask.
module cam_first_resolver #(
  parameter int N_WORDS = 100,
  parameter int IDX_W   = $clog2(N_WORDS)
) (
  input  logic [N_WORDS-1:0] vec_i,
  output logic               found_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic [N_WORDS-1:0] onehot_o
);

  localparam int LVLS = $clog2(N_WORDS);

  // pfx[LVLS][i] is the OR of vec_i[0..i] (inclusive prefix)
  logic [N_WORDS-1:0] pfx [LVLS+1];

  always_comb begin
    pfx[0] = vec_i;
    for (int l = 0; l < LVLS; l++) begin
      pfx[l+1] = pfx[l] | (pfx[l] << (1 << l));
    end
  end

  assign found_o  = pfx[LVLS][N_WORDS-1];
  assign onehot_o = vec_i & ~(pfx[LVLS] << 1);

  always_comb begin
    idx_o = '0;
    for (int i = 0; i < N_WORDS; i++) begin
      if (onehot_o[i]) idx_o = idx_o | IDX_W'(i);
    end
  end

endmodule

// File: rtl/cam_tag_array.sv
// Tag register file for the CAM parallel processor: captures match lines, combines them with
// existing tags and resolves multiple responders (select-first and one-per-cycle stepping).
module cam_tag_array
  import cam_pkg::*;
#(
  parameter int N_WORDS = 100,
  parameter int IDX_W   = $clog2(N_WORDS),
  parameter int CNT_W   = $clog2(N_WORDS + 1)
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               op_valid,
  input  tag_op_t            op,
  input  logic [N_WORDS-1:0] match_lines,
  output logic [N_WORDS-1:0] tags,
  output logic               some,
  output logic               none,
  output logic [IDX_W-1:0]   first_idx,
  output logic               step_valid,
  output logic [IDX_W-1:0]   step_idx,
  output logic [CNT_W-1:0]   step_count
);

  logic [N_WORDS-1:0] tags_q, tags_d;
  logic               step_valid_q, step_valid_d;
  logic [IDX_W-1:0]   step_idx_q, step_idx_d;
  logic [CNT_W-1:0]   step_count_q, step_count_d;

  logic               found;
  logic [IDX_W-1:0]   ff_idx;
  logic [N_WORDS-1:0] ff_onehot;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_W'(N_WORDS)) ? c : c + CNT_W'(1);
  endfunction

  cam_first_resolver #(
    .N_WORDS (N_WORDS),
    .IDX_W   (IDX_W)
  ) u_first (
    .vec_i    (tags_q),
    .found_o  (found),
    .idx_o    (ff_idx),
    .onehot_o (ff_onehot)
  );

  always_comb begin
    tags_d       = tags_q;
    step_valid_d = 1'b0;
    step_idx_d   = step_idx_q;
    step_count_d = step_count_q;
    if (op_valid) begin
      case (op)
        TAG_SET_ALL: begin
          tags_d       = '1;
          step_count_d = '0;
        end
        TAG_CLEAR_ALL: begin
          tags_d       = '0;
          step_count_d = '0;
        end
        TAG_LOAD: begin
          tags_d       = match_lines;
          step_count_d = '0;
        end
        TAG_AND:          tags_d = tags_q & match_lines;
        TAG_OR:           tags_d = tags_q | match_lines;
        TAG_SELECT_FIRST: tags_d = ff_onehot;
        TAG_STEP: begin
          // An empty array makes STEP a no-op, including the counter
          if (found) begin
            tags_d       = tags_q & ~ff_onehot;
            step_valid_d = 1'b1;
            step_idx_d   = ff_idx;
            step_count_d = sat_inc(step_count_q);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tags_q       <= '0;
      step_valid_q <= 1'b0;
      step_idx_q   <= '0;
      step_count_q <= '0;
    end else begin
      tags_q       <= tags_d;
      step_valid_q <= step_valid_d;
      step_idx_q   <= step_idx_d;
      step_count_q <= step_count_d;
    end
  end

  assign tags       = tags_q;
  assign some       = found;
  assign none       = ~found;
  assign first_idx  = ff_idx;
  assign step_valid = step_valid_q;
  assign step_idx   = step_idx_q;
  assign step_count = step_count_q;

endmodule
